// File: rtl/square_map_writer.sv
// rtl/square_map_writer.sv - draws tetromino cells or clears the square map, one registered write per cycle
// GHOST command support is compiled in only when SQUARE_MAP_GHOST_EN is defined.
module square_map_writer #(
   parameter int MAP_WIDTH = 14,
   parameter int MAP_ROWS  = 24
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [2:0] piece,
   input  logic [1:0] rot,
   input  logic [3:0] col,
   input  logic [4:0] row,
   output logic       write_enable,
   output logic [8:0] square_write_addr,
   output logic [3:0] write_color,
   output logic       busy,
   output logic       done,
   output logic       clipped
);

   localparam int         MAP_CELLS = MAP_WIDTH * MAP_ROWS;
   localparam logic [8:0] LAST_ADDR = 9'(MAP_CELLS - 1);
   localparam logic [1:0] CMD_DRAW  = 2'd1;
   localparam logic [1:0] CMD_GHOST = 2'd2;
   localparam logic [1:0] CMD_CLEAR = 2'd3;

`ifdef SQUARE_MAP_GHOST_EN
   localparam bit GHOST_EN = 1'b1;
`else
   localparam bit GHOST_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CELLS, CLEAR, DONE} state_t;

   state_t     state, state_next;
   logic [1:0] cell_idx, idx_next;
   logic [8:0] clear_addr, clear_next;
   logic       load;
   logic [1:0] l_cmd, l_rot;
   logic [2:0] l_piece;
   logic [3:0] l_col;
   logic [4:0] l_row;

   logic       we_next, busy_next, done_next, clipped_next;
   logic [8:0] addr_next;
   logic [3:0] color_next;

   logic       accepting;
   logic [1:0] src_cmd, src_rot, src_k;
   logic [2:0] src_piece;
   logic [3:0] src_col;
   logic [4:0] src_row;
   logic [3:0] offset;
   int         cell_x, cell_y, cell_lin;
   logic       cell_clip;
   logic [8:0] cell_addr;
   logic [3:0] cell_color;

   // Rotation-0 offsets packed {dx,dy} per cell, cell 0 in the top nibble.
   function automatic logic [3:0] base_offset(input logic [2:0] p, input logic [1:0] k);
      logic [15:0] tbl;
      case (p)
         3'd1:    tbl = {2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
         3'd2:    tbl = {2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
         3'd4:    tbl = {2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
         3'd5:    tbl = {2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
         3'd6:    tbl = {2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
         3'd7:    tbl = {2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1};
         default: tbl = {2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      endcase
      return tbl[(3 - int'(k)) * 4 +: 4];
   endfunction

   function automatic logic [2:0] shape_size(input logic [2:0] p);
      case (p)
         3'd7:       return 3'd4;
         3'd0, 3'd3: return 3'd2;
         default:    return 3'd3;
      endcase
   endfunction

   // Each quarter-turn maps (dx,dy) to (n-1-dy, dx) inside the n x n bounding box.
   function automatic logic [3:0] rotate(input logic [3:0] dxy, input logic [1:0] r,
                                         input logic [2:0] n);
      logic [1:0] dx, dy, t;
      dx = dxy[3:2];
      dy = dxy[1:0];
      for (int i = 0; i < 3; i++) begin
         if (i < int'(r)) begin
            t  = dx;
            dx = 2'(n - 3'd1 - {1'b0, dy});
            dy = t;
         end
      end
      return {dx, dy};
   endfunction

   assign accepting = (state == IDLE) || (state == DONE);

   // Cell 0 comes straight from the ports on the accepting edge; later cells from the latched command.
   always_comb begin
      if (accepting) begin
         src_cmd   = cmd;
         src_piece = piece;
         src_rot   = rot;
         src_col   = col;
         src_row   = row;
         src_k     = 2'd0;
      end else begin
         src_cmd   = l_cmd;
         src_piece = l_piece;
         src_rot   = l_rot;
         src_col   = l_col;
         src_row   = l_row;
         src_k     = cell_idx + 2'd1;
      end
      offset    = rotate(base_offset(src_piece, src_k), src_rot, shape_size(src_piece));
      cell_x    = int'(src_col) + int'(offset[3:2]);
      cell_y    = int'(src_row) + int'(offset[1:0]);
      cell_lin  = cell_y * MAP_WIDTH + cell_x;
      cell_clip = (cell_x >= MAP_WIDTH) || (cell_y >= MAP_ROWS);
      cell_addr = cell_clip ? 9'd0 : 9'(cell_lin);
      cell_color = 4'd0;
      if (!cell_clip && src_piece != 3'd0) begin
         if (src_cmd == CMD_DRAW)
            cell_color = {1'b0, src_piece};
         else if (src_cmd == CMD_GHOST)
            cell_color = {1'b1, src_piece};
      end
   end

   always_comb begin
      state_next   = state;
      idx_next     = cell_idx;
      clear_next   = clear_addr;
      load         = 1'b0;
      we_next      = 1'b0;
      addr_next    = 9'd0;
      color_next   = 4'd0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      clipped_next = clipped;
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (start) begin
               load         = 1'b1;
               clipped_next = 1'b0;
               if (cmd == CMD_CLEAR) begin
                  state_next = CLEAR;
                  clear_next = 9'd0;
                  we_next    = 1'b1;
                  busy_next  = 1'b1;
               end else if (cmd == CMD_GHOST && !GHOST_EN) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next   = CELLS;
                  idx_next     = 2'd0;
                  busy_next    = 1'b1;
                  we_next      = !cell_clip;
                  addr_next    = cell_addr;
                  color_next   = cell_color;
                  clipped_next = cell_clip;
               end
            end
         end
         CELLS: begin
            if (cell_idx == 2'd3) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               idx_next     = cell_idx + 2'd1;
               busy_next    = 1'b1;
               we_next      = !cell_clip;
               addr_next    = cell_addr;
               color_next   = cell_color;
               clipped_next = clipped | cell_clip;
            end
         end
         CLEAR: begin
            if (clear_addr == LAST_ADDR) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               clear_next = clear_addr + 9'd1;
               we_next    = 1'b1;
               addr_next  = clear_addr + 9'd1;
               busy_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cell_idx          <= 2'd0;
         clear_addr        <= 9'd0;
         l_cmd             <= 2'd0;
         l_piece           <= 3'd0;
         l_rot             <= 2'd0;
         l_col             <= 4'd0;
         l_row             <= 5'd0;
         write_enable      <= 1'b0;
         square_write_addr <= 9'd0;
         write_color       <= 4'd0;
         busy              <= 1'b0;
         done              <= 1'b0;
         clipped           <= 1'b0;
      end else begin
         cell_idx          <= idx_next;
         clear_addr        <= clear_next;
         if (load) begin
            l_cmd   <= cmd;
            l_piece <= piece;
            l_rot   <= rot;
            l_col   <= col;
            l_row   <= row;
         end
         write_enable      <= we_next;
         square_write_addr <= addr_next;
         write_color       <= color_next;
         busy              <= busy_next;
         done              <= done_next;
         clipped           <= clipped_next;
      end
   end

endmodule

// File: doc/square_map_writer.md
SQUARE_MAP_WRITER -- requirements
Module: square_map_writer

Interface
REQ-001 Parameter MAP_WIDTH, default 14: square map row pitch in words.
REQ-002 Parameter MAP_ROWS, default 24: map rows; valid addresses 0..MAP_WIDTH*MAP_ROWS-1 (default 0..335).
REQ-003 clk_in  input  1  sole clock; all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  command request; sampled only when busy=0.
REQ-006 cmd  input  2  0=ERASE, 1=DRAW, 2=GHOST, 3=CLEAR.
REQ-007 piece  input  3  color/shape code: 1=Z red, 2=L orange, 3=O yellow, 4=S green, 5=J blue, 6=T purple, 7=I cyan.
REQ-008 rot  input  2  clockwise quarter-turns, 0..3.
REQ-009 col  input  4  map column of shape bounding-box origin.
REQ-010 row  input  5  map row of shape bounding-box origin.
REQ-011 write_enable  output  1  square map write strobe.
REQ-012 square_write_addr  output  9  square map write address.
REQ-013 write_color  output  4  write data; bit3=ghost, bits2:0=color.
REQ-014 busy  output  1  command in progress.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 clipped  output  1  last command suppressed at least one off-map cell.

Function
REQ-017 FSM states IDLE, CELLS, CLEAR, DONE; IDLE->CELLS on start with cmd 0..2, IDLE->CLEAR on start with cmd=3, CELLS->DONE after cell 3, CLEAR->DONE after last address, DONE->IDLE unconditionally.
REQ-018 cmd, piece, rot, col, row SHALL be latched on the accepting edge; later input changes SHALL not affect the command.
REQ-019 Rot-0 offsets (dx,dy), dy downward, cell order 0..3: Z (0,0)(1,0)(1,1)(2,1); L (2,0)(0,1)(1,1)(2,1); O (0,0)(1,0)(0,1)(1,1); S (1,0)(2,0)(0,1)(1,1); J (0,0)(0,1)(1,1)(2,1); T (1,0)(0,1)(1,1)(2,1); I (0,1)(1,1)(2,1)(3,1).
REQ-020 Each quarter-turn SHALL map (dx,dy) to (N-1-dy, dx), N=4 for I, 2 for O, 3 otherwise; cell order preserved.
REQ-021 Cell address SHALL be (row+dy)*MAP_WIDTH + (col+dx), computed without truncation before range check.
REQ-022 Start accepted at edge T: cell k SHALL drive outputs in cycle T+1+k (k=0..3), one cell per cycle, all outputs registered.
REQ-023 A cell with col+dx >= MAP_WIDTH or row+dy >= MAP_ROWS SHALL keep its cycle slot with write_enable=0 and SHALL set clipped.
REQ-024 write_color: ERASE=0, DRAW={0,piece}, GHOST per REQ-035/036; piece=0 SHALL write 0.
REQ-025 CLEAR SHALL write color 0 to addresses 0..MAP_WIDTH*MAP_ROWS-1 ascending, one per cycle, starting T+1.
REQ-026 busy SHALL be 1 from T+1 through the last write cycle; done SHALL be 1 exactly in the cycle after, with busy=0.
REQ-027 start SHALL be ignored while busy=1; start in the done cycle SHALL be accepted.
REQ-028 clipped SHALL clear on command acceptance and hold its value until the next acceptance.
REQ-029 When write_enable=0, square_write_addr and write_color SHALL be 0.

Reset
REQ-030 rst_in assertion SHALL immediately force state IDLE and all outputs to 0, including mid-command.
REQ-031 An aborted command SHALL produce no further writes and no done pulse.
REQ-032 First start SHALL be accepted on the first rising edge after rst_in deasserts.

Configuration
REQ-033 Macro SQUARE_MAP_GHOST_EN selects GHOST support.
REQ-034 GHOST pieces render via the map's ghost bit (bit3).
REQ-035 Defined: GHOST SHALL behave as DRAW with write_color={1,piece}.
REQ-036 Undefined: GHOST SHALL perform zero writes; IDLE->DONE directly, done at T+1, busy never asserted, clipped=0.

Verification
REQ-037 DRAW T rot0 col3 row1 -> writes at T+1..T+4 to 18,31,32,33, color 4'h6; done at T+5; clipped=0.
REQ-038 DRAW I rot1 col3 row0 -> addresses 5,19,33,47, color 4'h7.
REQ-039 DRAW O rot0 col13 row0 -> cycle 0 writes 13, cycle 1 enable=0, cycle 2 writes 27, cycle 3 enable=0; clipped=1; done at T+5.
REQ-040 CLEAR -> 336 writes, addresses 0..335, color 0; done at T+337; start pulses while busy ignored.
REQ-041 GHOST T rot0 col3 row1 -> with macro: addresses 18,31,32,33, color 4'hE; without: no writes, done at T+1.
REQ-042 rst_in asserted at T+100 of CLEAR -> outputs 0 same cycle, no done; new DRAW after release completes normally.
